// File: rtl/sfp_telemetry_rx.sv
// SFP master-side telemetry receiver: per-slave 9-word frame assembly with atomic commit,
// staleness timeout and response capture. Optional statistics under `SFP_RX_STAT_EN.
module sfp_telemetry_rx #(
  parameter int unsigned TIMEOUT_CYC = 120000,
  parameter int unsigned TO_W        = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_channel_up,
  input  logic [63:0] s_rx_sfp_tdata,
  input  logic        s_rx_sfp_tvalid,
  output logic        s_rx_sfp_tready,
  input  logic [1:0]  i_rd_slave,
  input  logic [3:0]  i_rd_idx,
  output logic [31:0] o_rd_data,
  output logic [2:0]  o_frame_stb,
  output logic [2:0]  o_seq_err,
  output logic [2:0]  o_stale,
  output logic [63:0] o_rsp_data,
  output logic        o_rsp_valid,
  output logic        o_rsp_ovf,
  input  logic        i_rsp_clr,
  input  logic        i_stat_clr
);

  localparam logic [TO_W-1:0] LP_TO_MAX = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] LP_TO_PRE = TO_W'(TIMEOUT_CYC - 1);

  logic [31:0] w_cmd;
  logic [31:0] w_data;
  logic [1:0]  w_id;
  logic [3:0]  w_idx;
  logic        w_acc;
  logic        w_is_tlm;
  logic        w_rsp;
  logic [2:0]  w_hit;
  logic [2:0]  w_commit;
  logic [2:0]  w_err;
  logic [1:0]  w_rd_s;

  logic [3:0]      r_exp    [0:2];
  logic [TO_W-1:0] r_to     [0:2];
  logic [31:0]     r_shadow [0:2][0:7];
  logic [31:0]     r_live   [0:2][0:8];

  assign s_rx_sfp_tready = 1'b1;
  assign w_cmd    = s_rx_sfp_tdata[63:32];
  assign w_data   = s_rx_sfp_tdata[31:0];
  assign w_id     = w_cmd[29:28];
  assign w_idx    = w_cmd[3:0];
  assign w_acc    = s_rx_sfp_tvalid & i_channel_up;
  assign w_is_tlm = (w_cmd[31:30] == 2'b00) && (w_cmd[27:4] == 24'h200000) &&
                    (w_idx <= 4'd8) && (w_id != 2'd0);
  assign w_rsp    = w_acc & ~w_is_tlm;
  assign w_rd_s   = i_rd_slave - 2'd1;

  always_comb begin
    w_hit    = '0;
    w_commit = '0;
    w_err    = '0;
    for (int unsigned s = 0; s < 3; s++) begin
      w_hit[s]    = w_acc & w_is_tlm & (w_id == 2'(s + 1));
      w_commit[s] = w_hit[s] & (w_idx == r_exp[s]) & (w_idx == 4'd8);
      w_err[s]    = w_hit[s] & (w_idx != r_exp[s]);
    end
  end

  // Assembler, live bank, timeout and response capture share one register block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < 3; s++) begin
        r_exp[s] <= '0;
        r_to[s]  <= '0;
        for (int unsigned w = 0; w < 8; w++) r_shadow[s][w] <= '0;
        for (int unsigned w = 0; w < 9; w++) r_live[s][w] <= '0;
      end
      o_frame_stb <= '0;
      o_seq_err   <= '0;
      o_stale     <= '1;
      o_rsp_data  <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_ovf   <= 1'b0;
    end else begin
      o_frame_stb <= w_commit;
      o_seq_err   <= w_err;
      for (int unsigned s = 0; s < 3; s++) begin
        if (!i_channel_up) begin
          r_exp[s]   <= '0;
          r_to[s]    <= '0;
          o_stale[s] <= 1'b1;
        end else begin
          if (r_to[s] != LP_TO_MAX) begin
            r_to[s] <= r_to[s] + 1'b1;
            if (r_to[s] == LP_TO_PRE) o_stale[s] <= 1'b1;
          end
          // Later assignments here override the timeout update, so a commit wins.
          if (w_hit[s]) begin
            if (w_idx == r_exp[s]) begin
              if (w_idx == 4'd8) begin
                for (int unsigned w = 0; w < 8; w++) r_live[s][w] <= r_shadow[s][w];
                r_live[s][8] <= w_data;
                r_exp[s]     <= '0;
                r_to[s]      <= '0;
                o_stale[s]   <= 1'b0;
              end else begin
                r_shadow[s][w_idx[2:0]] <= w_data;
                r_exp[s]                <= w_idx + 4'd1;
              end
            end else if (w_idx == 4'd0) begin
              r_shadow[s][0] <= w_data;
              r_exp[s]       <= 4'd1;
            end else begin
              r_exp[s] <= '0;
            end
          end
        end
      end
      if (w_rsp) begin
        o_rsp_data  <= s_rx_sfp_tdata;
        o_rsp_valid <= 1'b1;
        if (i_rsp_clr)        o_rsp_ovf <= 1'b0;
        else if (o_rsp_valid) o_rsp_ovf <= 1'b1;
      end else if (i_rsp_clr) begin
        o_rsp_valid <= 1'b0;
        o_rsp_ovf   <= 1'b0;
      end
    end
  end

`ifdef SFP_RX_STAT_EN
  logic [15:0] r_frame_cnt [0:2];
  logic [15:0] r_err_cnt   [0:2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < 3; s++) begin
        r_frame_cnt[s] <= '0;
        r_err_cnt[s]   <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < 3; s++) begin
        if (i_stat_clr) begin
          r_frame_cnt[s] <= '0;
          r_err_cnt[s]   <= '0;
        end else begin
          if (w_commit[s] && (r_frame_cnt[s] != '1)) r_frame_cnt[s] <= r_frame_cnt[s] + 1'b1;
          if (w_err[s] && (r_err_cnt[s] != '1))       r_err_cnt[s]   <= r_err_cnt[s] + 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = i_stat_clr;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_data <= '0;
    end else if (i_rd_slave == 2'd0) begin
      o_rd_data <= '0;
    end else if (i_rd_idx <= 4'd8) begin
      o_rd_data <= r_live[w_rd_s][i_rd_idx];
`ifdef SFP_RX_STAT_EN
    end else if (i_rd_idx == 4'd9) begin
      o_rd_data <= {r_err_cnt[w_rd_s], r_frame_cnt[w_rd_s]};
`endif
    end else begin
      o_rd_data <= '0;
    end
  end

endmodule
